// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, pipelined imem requests, in-order fetch buffer, redirect squash.
// Optional build macro: FETCH_MISALIGN_CHECK_EN (halt and flag on misaligned redirect targets).

// Generic in-order FIFO with synchronous clear.
// Latency: write visible at rd_dat on the cycle after the push (no bypass).
// Backpressure: writes are dropped when full unless a read frees a slot that cycle.
module fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr_en;
    logic          rd_en;

    assign rd_en  = rd_rdy && (cnt != '0);
    assign wr_en  = wr_vld && ((cnt != (AW+1)'(DEPTH)) || rd_en);
    assign rd_dat = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr_en && !clr) begin
            mem[wptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
endmodule

// Fetch unit: owns the PC, issues credit-limited requests, buffers responses for decode.
// Latency: grant -> dec_valid is at least 2 cycles (response cycle plus buffer write).
// Backpressure: requests stop when buffered plus outstanding reaches BUF_DEPTH.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [4:0]  dec_opcode,
    output logic        misalign_err
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [31:0]   pc;
    logic [CW-1:0] buf_cnt;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW:0]   inflight;
    logic [63:0]   head;
    logic [31:0]   tag_pc;
    logic          grant;
    logic          push;
    logic          pop;
    logic          halted;

`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFF;
    logic halt_q;

    // A misaligned target is still loaded into pc but never fetched.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q <= 1'b0;
        end else if (redirect_valid) begin
            halt_q <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign halted       = halt_q;
    assign misalign_err = halt_q;
`else
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
    assign halted       = 1'b0;
    assign misalign_err = 1'b0;
`endif

    assign inflight  = {1'b0, buf_cnt} + {1'b0, out_cnt};
    assign imem_req  = !rst && !halted && !redirect_valid && (inflight < (CW+1)'(BUF_DEPTH));
    assign imem_addr = pc;
    assign grant     = imem_req && imem_gnt;

    assign push = imem_rvalid && (drop_cnt == '0) && !redirect_valid;
    assign pop  = dec_valid && dec_ready && !redirect_valid;

    // Tag queue occupancy is exactly the number of outstanding requests.
    fifo #(.W(32), .DEPTH(BUF_DEPTH)) u_tag_q (
        .clk    (clk),
        .rst    (rst),
        .clr    (1'b0),
        .wr_vld (grant),
        .wr_dat (pc),
        .rd_rdy (imem_rvalid),
        .rd_dat (tag_pc),
        .cnt    (out_cnt)
    );

    fifo #(.W(64), .DEPTH(BUF_DEPTH)) u_buf (
        .clk    (clk),
        .rst    (rst),
        .clr    (redirect_valid),
        .wr_vld (push),
        .wr_dat ({imem_rdata, tag_pc}),
        .rd_rdy (pop),
        .rd_dat (head),
        .cnt    (buf_cnt)
    );

    assign dec_valid  = (buf_cnt != '0);
    assign dec_instr  = dec_valid ? head[63:32] : 32'h0;
    assign dec_pc     = dec_valid ? head[31:0]  : 32'h0;
    assign dec_opcode = dec_instr[6:2];

    // On redirect every response still in flight is wrong-path, except one arriving this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc & PC_MASK;
            drop_cnt <= out_cnt - CW'(imem_rvalid);
        end else begin
            if (grant) pc <= pc + 32'd4;
            if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory responder with random latency and a PC-stream reference model.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [4:0]  dec_opcode;
    logic        misalign_err;

    fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_opcode     (dec_opcode),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gnt_pct = 100;
    int lat_lo = 1;
    int lat_hi = 1;
    int grant_cnt = 0;
    int pops = 0;
    int first_gnt_cyc = -1;
    int first_vld_cyc = -1;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] pop_log[$];

    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } req_t;
    req_t mq[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ (a << 16);
    endfunction

    function automatic logic [31:0] get_log(input int i);
        if (i < pop_log.size()) return pop_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        tick(1);
        redirect_valid = 1'b0;
    endtask

    // Memory drive side: grant randomly, answer the oldest request once its latency has elapsed.
    always @(posedge clk) begin
        cyc++;
        #1;
        imem_gnt = ($urandom_range(99) < gnt_pct);
        if (!rst && mq.size() > 0 && mq[0].rdy <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    // Memory observe side: retire answered requests, record new transfers.
    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
        end else begin
            if (imem_rvalid && mq.size() > 0) mq.delete(0);
            if (imem_req && imem_gnt) begin
                if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
                mq.push_back('{imem_addr, cyc + $urandom_range(lat_hi, lat_lo)});
                grant_cnt++;
            end
            chk("outstanding_cap", 32'(mq.size() <= BUF_DEPTH), 32'd1);
        end
    end

    // Reference model: decode must see a contiguous word stream starting at the last redirect target.
    always @(negedge clk) begin
        logic [31:0] w;
        if (rst) begin
            exp_pc = RESET_PC;
        end else begin
            if (first_vld_cyc < 0 && dec_valid) first_vld_cyc = cyc;
            chk("credit_inv", 32'(int'(u_dut.buf_cnt) + int'(u_dut.out_cnt) <= BUF_DEPTH), 32'd1);
            if (imem_req) chk("addr_aligned", {30'h0, imem_addr[1:0]}, 32'h0);
            if (redirect_valid) begin
                chk("req_in_redirect", 32'(imem_req), 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
                exp_pc = redirect_pc;
`else
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
            end else if (dec_valid && dec_ready) begin
                w = mem_word(exp_pc);
                chk("dec_pc", dec_pc, exp_pc);
                chk("dec_instr", dec_instr, w);
                chk("dec_opcode", 32'(dec_opcode), 32'(w[6:2]));
                pop_log.push_back(dec_pc);
                pops++;
                exp_pc = exp_pc + 32'd4;
            end
            if (!dec_valid) chk("empty_zero", dec_instr | dec_pc | 32'(dec_opcode), 32'h0);
        end
    end

    initial begin
        int idx;
        int p0;
        int gc;
        int exp_drop;
        bit found;
        logic [31:0] r;

        rst            = 1'b1;
        dec_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        tick(3);

        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_dec_valid", 32'(dec_valid), 32'h0);
        chk("rst_dec_instr", dec_instr, 32'h0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_dec_opcode", 32'(dec_opcode), 32'h0);
        chk("rst_misalign", 32'(misalign_err), 32'h0);
        chk("rst_addr", imem_addr, RESET_PC);

        // Streaming from reset with a one-cycle memory.
        rst = 1'b0;
        tick(8);
        chk("first_latency", 32'(first_vld_cyc - first_gnt_cyc), 32'd2);
        chk("seq0", get_log(0), RESET_PC);
        chk("seq1", get_log(1), RESET_PC + 32'h4);
        chk("seq2", get_log(2), RESET_PC + 32'h8);
        chk("seq3", get_log(3), RESET_PC + 32'hC);

        // Decode stall: credit caps fetch at BUF_DEPTH words.
        dec_ready = 1'b0;
        tick(10);
        chk("stall_req", 32'(imem_req), 32'h0);
        chk("stall_outstanding", 32'(mq.size()), 32'h0);
        chk("stall_valid", 32'(dec_valid), 32'h1);
        p0 = pops;
        gnt_pct = 0;
        dec_ready = 1'b1;
        tick(4);
        chk("stall_buffered", 32'(pops - p0), 32'(BUF_DEPTH));
        gnt_pct = 100;
        tick(4);

        // Two requests outstanding then redirect: both responses must be squashed.
        gnt_pct = 0;
        tick(5);
        lat_lo = 4;
        lat_hi = 4;
        gnt_pct = 100;
        do_redirect(32'h0000_0010);
        tick(2);
        chk("two_outstanding", 32'(mq.size()), 32'd2);
        if (mq.size() == 2) begin
            chk("out_addr0", mq[0].addr, 32'h0000_0010);
            chk("out_addr1", mq[1].addr, 32'h0000_0014);
        end
        idx = pop_log.size();
        do_redirect(32'h0000_0200);
        chk("flush_empty", 32'(dec_valid), 32'h0);
        chk("drop_cnt_two", 32'(u_dut.drop_cnt), 32'd2);
        tick(12);
        chk("after_flush_pc0", get_log(idx), 32'h0000_0200);
        chk("after_flush_pc1", get_log(idx + 1), 32'h0000_0204);

        // Redirect coinciding with a response and a pop.
        lat_lo = 2;
        lat_hi = 2;
        found = 1'b0;
        exp_drop = 0;
        idx = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick(1);
            if (imem_rvalid && dec_valid) begin
                found = 1'b1;
                exp_drop = mq.size() - 1;
                idx = pop_log.size();
                do_redirect(32'h0000_0300);
                chk("drop_cnt_rvalid", 32'(u_dut.drop_cnt), 32'(exp_drop));
            end
        end
        chk("coincide_found", 32'(found), 32'h1);
        tick(10);
        chk("coincide_pc", get_log(idx), 32'h0000_0300);

        // PC wrap at the top of the address space.
        lat_lo = 1;
        lat_hi = 1;
        idx = pop_log.size();
        do_redirect(32'hFFFF_FFF8);
        tick(10);
        chk("wrap0", get_log(idx), 32'hFFFF_FFF8);
        chk("wrap1", get_log(idx + 1), 32'hFFFF_FFFC);
        chk("wrap2", get_log(idx + 2), 32'h0000_0000);

        // Misaligned redirect target.
`ifdef FETCH_MISALIGN_CHECK_EN
        do_redirect(32'h0000_0102);
        gc = grant_cnt;
        for (int i = 0; i < 5; i++) begin
            chk("mis_err", 32'(misalign_err), 32'h1);
            chk("mis_req", 32'(imem_req), 32'h0);
            tick(1);
        end
        chk("mis_no_grant", 32'(grant_cnt - gc), 32'h0);
        idx = pop_log.size();
        do_redirect(32'h0000_0104);
        chk("mis_clear", 32'(misalign_err), 32'h0);
        tick(8);
        chk("mis_resume", get_log(idx), 32'h0000_0104);
`else
        idx = pop_log.size();
        do_redirect(32'h0000_0102);
        chk("mis_err_off", 32'(misalign_err), 32'h0);
        tick(8);
        chk("mis_forced", get_log(idx), 32'h0000_0100);
`endif

        // Randomized traffic with redirects, stalls and variable latency.
        gnt_pct = 70;
        lat_lo = 1;
        lat_hi = 4;
        p0 = pops;
        for (int i = 0; i < 3000; i++) begin
            dec_ready = ($urandom_range(99) < 70);
            if ($urandom_range(99) < 3) begin
                r = $urandom() & 32'hFFFF_FFFC;
                redirect_valid = 1'b1;
                redirect_pc    = r;
            end else begin
                redirect_valid = 1'b0;
            end
            tick(1);
        end
        redirect_valid = 1'b0;
        dec_ready = 1'b1;
        tick(20);
        chk("random_progress", 32'(pops - p0 > 500), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
